// File: rtl/multiply_booth_seq.sv
// multiply_booth_seq
//   Iterative radix-4 Booth multiplier for the datapath MUL unit. One Booth
//   digit is retired per clock. Operands are signed or unsigned, chosen per
//   operation with signed_en. The 2*WIDTH product is registered on HI/LO.
//
//   Optional build macro: MUL_EARLY_TERM_EN
//     When defined, the operation finishes as soon as every remaining
//     multiplier digit is zero. Results are identical; only done timing moves.
//
// Ports
//   clock      in   rising-edge system clock
//   clear      in   synchronous active-high reset (priority over everything)
//   start      in   operation request, sampled only while idle
//   signed_en  in   1 = two's-complement operands, 0 = unsigned
//   Ra         in   multiplicand (captured with start)
//   Rb         in   multiplier   (captured with start)
//   busy       out  operation in flight
//   done       out  one-cycle pulse, HI/LO valid from this cycle
//   HI         out  product[2*WIDTH-1:WIDTH]
//   LO         out  product[WIDTH-1:0]
module multiply_booth_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH / 2 + 2)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int XW = WIDTH + 2;       // extended operand width
    localparam int AW = 2 * WIDTH + 4;   // accumulator width

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [XW-1:0]    mcand;
    logic [XW-1:0]    mult;
    logic             prev;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last_cnt;

    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    pp;
    logic [AW-1:0]    acc_next;
    logic [XW-1:0]    mult_next;
    logic             prev_next;
    logic             finish;
    logic             ext_a;
    logic             ext_b;

    assign ext_a = signed_en & Ra[WIDTH-1];
    assign ext_b = signed_en & Rb[WIDTH-1];

    always_comb begin
        m_ext = {{(AW - XW){mcand[XW-1]}}, mcand};
        pp    = '0;
        case ({mult[1:0], prev})
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        // Partial product lands at weight 4^cnt.
        acc_next  = acc + (pp << {cnt, 1'b0});
        mult_next = {mult[XW-1], mult[XW-1], mult[XW-1:2]};
        prev_next = mult[1];
`ifdef MUL_EARLY_TERM_EN
        // Remaining bits all equal to prev means every later digit is zero.
        finish    = (cnt == last_cnt) || (mult_next == {XW{prev_next}});
`else
        finish    = (cnt == last_cnt);
`endif
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            mcand    <= '0;
            mult     <= '0;
            prev     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            last_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand    <= {ext_a, ext_a, Ra};
                        mult     <= {ext_b, ext_b, Rb};
                        prev     <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                        // Unsigned needs one extra digit for the zero top.
                        last_cnt <= signed_en ? CNT_W'(WIDTH / 2 - 1)
                                              : CNT_W'(WIDTH / 2);
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    mult <= mult_next;
                    prev <= prev_next;
                    cnt  <= cnt + 1'b1;
                    if (finish) begin
                        HI    <= acc_next[2*WIDTH-1:WIDTH];
                        LO    <= acc_next[WIDTH-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_booth_seq.sv
// tb_multiply_booth_seq
//   Directed bench for multiply_booth_seq (WIDTH=32): reset, signed and
//   unsigned products, corner operands, latency, clear mid-operation and
//   back-to-back start handshake.
module tb_multiply_booth_seq;

`ifdef MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        signed_en;
    logic [31:0] Ra;
    logic [31:0] Rb;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int compared   = 0;
    int mismatched = 0;

    multiply_booth_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .signed_en (signed_en),
        .Ra        (Ra),
        .Rb        (Rb),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done. lat < 0 skips the
    // latency comparison.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
        int seen;
        seen      = -1;
        Ra        = a;
        Rb        = b;
        signed_en = s;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check({tag, ".busy"}, 64'(busy), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                seen = c;
                break;
            end
        end
        check({tag, ".done_seen"}, 64'(seen >= 0), 64'd1);
        if (lat >= 0) check({tag, ".latency"}, 64'(seen), 64'(lat));
        check({tag, ".HI"}, 64'(HI), 64'(eh));
        check({tag, ".LO"}, 64'(LO), 64'(el));
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_cnt;
        int d1;
        int d2;

        clear     = 1'b1;
        start     = 1'b0;
        signed_en = 1'b0;
        Ra        = '0;
        Rb        = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.HI",   64'(HI),   64'd0);
        check("reset.LO",   64'(LO),   64'd0);
        clear = 1'b0;
        @(posedge clock);
        #1;

        run_op("s_m3x7",   32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, ET ? 2 : 16);
        run_op("u_ffxff",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, ET ? -1 : 17);
        run_op("s_ffxff",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, ET ? -1 : 16);
        run_op("s_minmin", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 16);
        run_op("s_zero",   32'h12345678, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, ET ? 1 : 16);
        run_op("u_8x2",    32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000, ET ? -1 : 17);
        run_op("s_7xbig",  32'h00000007, 32'h40000003, 1'b1, 32'h00000001, 32'hC0000015, 16);
`ifdef MUL_EARLY_TERM_EN
        run_op("et_5x3",   32'h00000005, 32'h00000003, 1'b1, 32'h00000000, 32'h0000000F, 2);
        run_op("et_rb0",   32'h00000005, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 1);
        run_op("et_max",   32'h00000005, 32'h7FFFFFFF, 1'b1, 32'h00000002, 32'h7FFFFFFB, 16);
`endif

        // Clear during step 5 abandons the operation; HI/LO (nonzero now) zero.
        Ra        = 32'h00000003;
        Rb        = 32'h40000003;
        signed_en = 1'b1;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("clr.busy", 64'(busy), 64'd0);
        check("clr.done", 64'(done), 64'd0);
        check("clr.HI",   64'(HI),   64'd0);
        check("clr.LO",   64'(LO),   64'd0);
        done_cnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clock);
            #1;
            if (done) done_cnt++;
        end
        check("clr.no_done", 64'(done_cnt), 64'd0);
        check("clr.HI_hold", 64'(HI), 64'd0);

        // start held high: op1 runs undisturbed, op2 is captured on the done
        // cycle, later operand changes are ignored.
        d1        = -1;
        d2        = -1;
        Ra        = 32'h00000007;
        Rb        = 32'h40000003;
        signed_en = 1'b1;
        start     = 1'b1;
        @(posedge clock);
        #1;
        Ra = 32'hFFFFFFFE;
        Rb = 32'h5A5A5A5A;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (c == 17) begin
                Ra        = 32'h11111111;
                Rb        = 32'h22222222;
                signed_en = 1'b0;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check("b2b.op1_HI", 64'(HI), 64'h00000001);
                    check("b2b.op1_LO", 64'(LO), 64'hC0000015);
                end else begin
                    d2 = c;
                    check("b2b.op2_HI", 64'(HI), 64'hFFFFFFFF);
                    check("b2b.op2_LO", 64'(LO), 64'h4B4B4B4C);
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b.first_done", 64'(d1), 64'd16);
        check("b2b.second_done", 64'(d2), 64'd33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multiply_booth_seq.md
Name: multiply_booth_seq

Overview:
- Parametrised, iterative radix-4 Booth multiplier for the datapath MUL unit.
- Retires one Booth digit per clock and supports signed or unsigned operands selected per operation.
- Uses a start/busy/done handshake and registers the HI/LO result.
- Sits beside the ALU; control unit pulses start and waits for done before writing HI/LO.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH/2+2), iteration counter width.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when busy=0.
- signed_en  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- Ra  in  WIDTH  multiplicand; captured with start.
- Rb  in  WIDTH  multiplier; captured with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO valid from this cycle.
- HI  out  WIDTH  upper half of the 2*WIDTH product.
- LO  out  WIDTH  lower half of the 2*WIDTH product.

Behaviour:
- Reset: clock and single reset clear only. Clock is clock; clear is synchronous, active-high.
- clear=1 at an edge forces: state IDLE, busy=0, done=0, HI=0, LO=0, counter=0, internal accumulator/operand registers=0.
- clear has priority over all other inputs, including mid-operation; any in-flight operation is abandoned and produces no done.
- States: IDLE, RUN.
- IDLE with start=1 at edge E0:
  - capture Ra/Rb/signed_en;
  - extend operands to WIDTH+2 bits, sign-extended if signed_en=1, else zero-extended;
  - clear accumulator, counter=0, prev bit=0;
  - go to RUN, busy=1.
- RUN, each edge:
  - decode the Booth digit from {mult[1:0], prev}: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M;
  - add into the accumulator at weight 4^counter;
  - shift multiplier right 2 (arithmetic), keeping the shifted-out bit as prev;
  - counter++.
- Step count N: WIDTH/2 when signed_en=1; WIDTH/2+1 when signed_en=0 (extra digit absorbs the zero-extended top).
- Completion: the edge performing step N (E_N):
  - writes HI/LO = product[2*WIDTH-1:WIDTH] / product[WIDTH-1:0];
  - sets done=1 for exactly one cycle;
  - sets busy=0 and returns to IDLE.
- Latency: done is high N cycles after the start edge. WIDTH=32 gives 16 (signed) or 17 (unsigned).
- HI/LO hold their last value until the next completion or clear; they never show partial sums.
- start while busy=1 is ignored; no queuing.
- start high in the done cycle is accepted (state is IDLE), giving back-to-back throughput of one result per N+1 cycles.
- Ra/Rb/signed_en changes after E0 have no effect on the in-flight operation.
- Arithmetic: accumulator is 2*WIDTH+4 bits, sign-correct. Full product is exact for all inputs, including most-negative × most-negative signed: 0x80000000 × 0x80000000 = 0x4000000000000000.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - after each step k (k>=1), if all remaining unscanned multiplier bits equal prev, every remaining digit is 0;
  - the block then finishes at that edge: final shift-aligned product to HI/LO, done=1, busy=0;
  - latency is k cycles, with minimum 1; worst case is unchanged at N.
- Not defined: always exactly N steps; no termination comparator is synthesised.
- Results are identical either way; only done timing differs.

Test Plan:
- Reset: clear=1 mid-RUN (step 5 of 16) -> next cycle busy=0, done=0, HI=LO=0. No done pulse follows even with clear released.
- Signed, WIDTH=32: Ra=0xFFFFFFFD (-3), Rb=0x00000007 -> done at cycle 16 after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- Unsigned: Ra=0xFFFFFFFF, Rb=0xFFFFFFFF, signed_en=0 -> done at cycle 17; HI=0xFFFFFFFE, LO=0x00000001.
  - Same operands with signed_en=1 -> HI=0, LO=1.
- Corner: signed 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
  - Ra=0x12345678 × Rb=0 -> HI=LO=0.
- Handshake: start held high continuously with changing operands -> second operation captured on the done cycle, done pulses every 17 cycles (signed). Operand changes mid-RUN do not alter results. start during busy does not restart.
- With MUL_EARLY_TERM_EN: signed Ra=5, Rb=3 -> done 2 cycles after start, LO=15, HI=0.
  - Rb=0 -> done after 1 cycle.
  - Rb=0x7FFFFFFF -> done after 16 cycles.
  - Results match the non-macro build for 10k random operand/mode pairs.
